alu_mc: RTL

- Parametrised WIDTH-bit ALU that replaces the per-bit slice chain with one registered word-level datapath.
- Adds a start/done handshake and a multi-cycle unsigned shift-add multiplier.
- Keeps the compare family selected by bonus_op (less, greater, le, ge, eq, ne).
- Sits between the decode/register-read stage and write-back in the multi-cycle CPU; the controller stalls on busy_o.

---
 rtl/alu_mc.sv | 220 ++++++++++++++++++++++
 1 files changed

// File: rtl/alu_mc.sv
// ============================================================================
// Module   : alu_mc
// Brief    : Registered word-level ALU with start/done handshake, compare
//            family and optional multi-cycle shift-add multiplier
//            (enabled by defining ALU_MC_MUL_EN).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_mc #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [3:0]       ctrl_i,
  input  logic [2:0]       bonus_op_i,
  input  logic [WIDTH-1:0] src1_i,
  input  logic [WIDTH-1:0] src2_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] result_o,
  output logic [WIDTH-1:0] hi_o,
  output logic             zero_o,
  output logic             cout_o,
  output logic             overflow_o,
  output logic             illegal_o
);

  localparam logic [3:0] C_OP_AND  = 4'd0;
  localparam logic [3:0] C_OP_OR   = 4'd1;
  localparam logic [3:0] C_OP_ADD  = 4'd2;
  localparam logic [3:0] C_OP_SUB  = 4'd6;
  localparam logic [3:0] C_OP_CMP  = 4'd7;
  localparam logic [3:0] C_OP_NOR  = 4'd12;
`ifdef ALU_MC_MUL_EN
  localparam logic [3:0] C_OP_MULU = 4'd8;
`endif

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_DONE = 2'd2
`ifdef ALU_MC_MUL_EN
    , S_MUL = 2'd3
`endif
  } state_t;

  state_t r_state, w_next;

  logic [WIDTH-1:0] r_a, r_b;
  logic [3:0]       r_ctrl;
  logic [2:0]       r_bop;
  logic [WIDTH-1:0] r_result;
  logic             r_zero, r_cout, r_ovf, r_illegal;

  logic [WIDTH:0]   w_sum, w_diff;
  logic             w_ovf_add, w_ovf_sub, w_less, w_equal, w_cmp;
  logic [WIDTH-1:0] w_res;
  logic             w_cout, w_ovf, w_ill;

`ifdef ALU_MC_MUL_EN
  logic [2*WIDTH-1:0] r_acc;
  logic [WIDTH-1:0]   r_hi;
  logic [CNT_W-1:0]   r_cnt;
  logic [WIDTH:0]     w_acc_sum;
  logic               w_mul_last;

  assign w_acc_sum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, r_a};
  assign w_mul_last = (r_cnt == CNT_W'(WIDTH));
  assign hi_o       = r_hi;
`else
  assign hi_o       = '0;
`endif

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (start_i) begin
`ifdef ALU_MC_MUL_EN
          if (ctrl_i == C_OP_MULU) w_next = S_MUL;
          else                     w_next = S_EXEC;
`else
          w_next = S_EXEC;
`endif
        end
      end
      S_EXEC:  w_next = S_DONE;
`ifdef ALU_MC_MUL_EN
      S_MUL:   if (w_mul_last) w_next = S_DONE;
`endif
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Word-level datapath evaluated on the latched operands during EXEC.
  assign w_sum     = {1'b0, r_a} + {1'b0, r_b};
  assign w_diff    = {1'b0, r_a} + {1'b0, ~r_b} + {{WIDTH{1'b0}}, 1'b1};
  assign w_ovf_add = (r_a[WIDTH-1] == r_b[WIDTH-1]) && (w_sum[WIDTH-1]  != r_a[WIDTH-1]);
  assign w_ovf_sub = (r_a[WIDTH-1] != r_b[WIDTH-1]) && (w_diff[WIDTH-1] != r_a[WIDTH-1]);
  assign w_less    = w_diff[WIDTH-1] ^ w_ovf_sub;
  assign w_equal   = (r_a == r_b);

  always_comb begin
    w_cmp = 1'b0;
    case (r_bop)
      3'd0:    w_cmp = w_less;
      3'd1:    w_cmp = ~w_less & ~w_equal;
      3'd2:    w_cmp = w_less | w_equal;
      3'd3:    w_cmp = ~w_less;
      3'd4:    w_cmp = w_equal;
      3'd5:    w_cmp = ~w_equal;
      default: w_cmp = 1'b0;
    endcase
  end

  always_comb begin
    w_res  = '0;
    w_cout = 1'b0;
    w_ovf  = 1'b0;
    w_ill  = 1'b0;
    case (r_ctrl)
      C_OP_AND: w_res = r_a & r_b;
      C_OP_OR:  w_res = r_a | r_b;
      C_OP_NOR: w_res = ~(r_a | r_b);
      C_OP_ADD: begin
        w_res  = w_sum[WIDTH-1:0];
        w_cout = w_sum[WIDTH];
        w_ovf  = w_ovf_add;
      end
      C_OP_SUB: begin
        w_res  = w_diff[WIDTH-1:0];
        w_cout = w_diff[WIDTH];
        w_ovf  = w_ovf_sub;
      end
      C_OP_CMP: w_res = {{(WIDTH-1){1'b0}}, w_cmp};
      default:  w_ill = 1'b1;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_a       <= '0;
      r_b       <= '0;
      r_ctrl    <= '0;
      r_bop     <= '0;
      r_result  <= '0;
      r_zero    <= 1'b1;
      r_cout    <= 1'b0;
      r_ovf     <= 1'b0;
      r_illegal <= 1'b0;
`ifdef ALU_MC_MUL_EN
      r_acc     <= '0;
      r_hi      <= '0;
      r_cnt     <= '0;
`endif
    end else begin
      if (r_state == S_IDLE && start_i) begin
        r_a    <= src1_i;
        r_b    <= src2_i;
        r_ctrl <= ctrl_i;
        r_bop  <= bonus_op_i;
`ifdef ALU_MC_MUL_EN
        r_acc  <= {{WIDTH{1'b0}}, src2_i};
        r_cnt  <= '0;
`endif
      end
      if (r_state == S_EXEC) begin
        r_result  <= w_res;
        r_zero    <= (w_res == '0);
        r_cout    <= w_cout;
        r_ovf     <= w_ovf;
        r_illegal <= w_ill;
`ifdef ALU_MC_MUL_EN
        r_hi      <= '0;
`endif
      end
`ifdef ALU_MC_MUL_EN
      // One multiplier bit per cycle, then one extra cycle to publish the product.
      if (r_state == S_MUL) begin
        if (w_mul_last) begin
          r_result  <= r_acc[WIDTH-1:0];
          r_hi      <= r_acc[2*WIDTH-1:WIDTH];
          r_zero    <= (r_acc[WIDTH-1:0] == '0);
          r_cout    <= 1'b0;
          r_ovf     <= 1'b0;
          r_illegal <= 1'b0;
        end else begin
          r_cnt <= r_cnt + 1'b1;
          if (r_acc[0]) r_acc <= {w_acc_sum, r_acc[WIDTH-1:1]};
          else          r_acc <= {1'b0, r_acc[2*WIDTH-1:1]};
        end
      end
`endif
    end
  end

`ifdef ALU_MC_MUL_EN
  assign busy_o = (r_state == S_EXEC) || (r_state == S_MUL);
`else
  assign busy_o = (r_state == S_EXEC);
`endif
  assign done_o     = (r_state == S_DONE);
  assign result_o   = r_result;
  assign zero_o     = r_zero;
  assign cout_o     = r_cout;
  assign overflow_o = r_ovf;
  assign illegal_o  = r_illegal;

endmodule

`default_nettype wire
